response_arbiter: RTL

//  Owns the single response channel (param_data/param_write/done) into the response framer.

---
 rtl/response_arbiter_pkg.sv | 18 +
 rtl/response_arbiter_if.sv | 38 +++
 rtl/response_arbiter_rr_pick.sv | 31 +++
 rtl/response_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/response_arbiter_pkg.sv
// Shared definitions for the response-channel arbiter: state encodings,
// the response-bus word width, and an index-width helper.
package response_arbiter_pkg;

  localparam int PARAM_W = 33;

  typedef enum logic [1:0] {
    RA_IDLE = 2'd0,
    RA_CMD  = 2'd1,
    RA_OWN  = 2'd2
  } ra_state_e;

  // At least one bit, so a single requester still gets a legal index vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/response_arbiter_if.sv
// Bundle of every channel the arbiter sees: command reply path, involuntary
// requesters, the framer-side output and the sticky error flags.
interface response_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int PARAM_W = response_arbiter_pkg::PARAM_W
);
  logic                    cmd_busy;
  logic [PARAM_W-1:0]      cmd_param_data;
  logic                    cmd_param_write;
  logic                    cmd_done;
  logic                    chan_busy;
  logic [NREQ-1:0]         invol_req;
  logic [NREQ-1:0]         invol_grant;
  logic [NREQ*PARAM_W-1:0] unit_param_data;
  logic [NREQ-1:0]         unit_param_write;
  logic [NREQ-1:0]         unit_done;
  logic [PARAM_W-1:0]      out_param_data;
  logic                    out_param_write;
  logic                    out_done;
  logic                    timeout_err;
  logic                    proto_err;

  modport slave (
    input  cmd_busy, cmd_param_data, cmd_param_write, cmd_done,
    input  invol_req, unit_param_data, unit_param_write, unit_done,
    output chan_busy, invol_grant,
    output out_param_data, out_param_write, out_done,
    output timeout_err, proto_err
  );

  modport master (
    output cmd_busy, cmd_param_data, cmd_param_write, cmd_done,
    output invol_req, unit_param_data, unit_param_write, unit_done,
    input  chan_busy, invol_grant,
    input  out_param_data, out_param_write, out_done,
    input  timeout_err, proto_err
  );
endinterface

// File: rtl/response_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request
// at or after ptr, wrapping back to index 0.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // First pass covers ptr..NREQ-1, second pass the wrapped part 0..ptr-1.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/response_arbiter.sv
// Owns the single response channel to the framer, sharing it between the
// command-reply path and NREQ involuntary reporters with round-robin fairness.
module response_arbiter #(
  parameter int NREQ    = 4,
  parameter int PARAM_W = response_arbiter_pkg::PARAM_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  response_arbiter_if.slave bus
);
  import response_arbiter_pkg::*;

  localparam int IDX_W = idx_width(NREQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  ra_state_e          state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [PARAM_W-1:0] out_data_q, out_data_d;
  logic               out_write_q, out_write_d;
  logic               out_done_q, out_done_d;
  logic               timeout_err_q, timeout_err_d;
  logic               proto_err_q, proto_err_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [PARAM_W-1:0] owner_data;
  logic               owner_write;
  logic               owner_done;
  logic [IDX_W-1:0]   next_ptr;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (bus.invol_req),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_data  = bus.unit_param_data[int'(owner_q)*PARAM_W +: PARAM_W];
  assign owner_write = bus.unit_param_write[owner_q];
  assign owner_done  = bus.unit_done[owner_q];
  assign next_ptr    = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = timer_q;
    grant_d       = '0;
    out_data_d    = out_data_q;
    out_write_d   = 1'b0;
    out_done_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    proto_err_d   = proto_err_q;

    case (state_q)
      RA_IDLE: begin
        if (bus.cmd_busy) begin
          state_d = RA_CMD;
        end else if (pick_any) begin
          owner_d = pick_idx;
          timer_d = '0;
          state_d = RA_OWN;
          for (int i = 0; i < NREQ; i++) begin
            grant_d[i] = (IDX_W'(i) == pick_idx);
          end
        end
      end

      RA_CMD: begin
        out_data_d  = bus.cmd_param_data;
        out_write_d = bus.cmd_param_write;
        out_done_d  = bus.cmd_done;
        if (bus.cmd_done) begin
          state_d = RA_IDLE;
        end
      end

      RA_OWN: begin
        timer_d = timer_q + 1'b1;
        if (bus.cmd_busy) begin
          proto_err_d = 1'b1;
        end
        // A real completion beats a coincident timeout.
        if (owner_done) begin
          out_data_d  = owner_data;
          out_write_d = owner_write;
          out_done_d  = 1'b1;
          rr_ptr_d    = next_ptr;
          state_d     = RA_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          out_done_d    = 1'b1;
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
          state_d       = RA_IDLE;
        end else begin
          out_data_d  = owner_data;
          out_write_d = owner_write;
        end
      end

      default: state_d = RA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RA_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      grant_q       <= '0;
      out_data_q    <= '0;
      out_write_q   <= 1'b0;
      out_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      timer_q       <= timer_d;
      grant_q       <= grant_d;
      out_data_q    <= out_data_d;
      out_write_q   <= out_write_d;
      out_done_q    <= out_done_d;
      timeout_err_q <= timeout_err_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // Busy straight from state so the dispatcher already sees it in the grant cycle.
  assign bus.chan_busy       = (state_q == RA_OWN);
  assign bus.invol_grant     = grant_q;
  assign bus.out_param_data  = out_data_q;
  assign bus.out_param_write = out_write_q;
  assign bus.out_done        = out_done_q;
  assign bus.timeout_err     = timeout_err_q;
  assign bus.proto_err       = proto_err_q;

endmodule
